// File: rtl/arbiter_rr5_pkg.sv
// Shared encodings for the five-port round-robin output arbiter.
package arbiter_rr5_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_L    = 6'b000010,
        ST_N    = 6'b000100,
        ST_E    = 6'b001000,
        ST_W    = 6'b010000,
        ST_S    = 6'b100000
    } state_t;

    typedef enum logic [2:0] {
        P_L = 3'd0,
        P_N = 3'd1,
        P_E = 3'd2,
        P_W = 3'd3,
        P_S = 3'd4
    } port_e;

    localparam logic [4:0] XSEL_IDLE = 5'b00000;
    localparam logic [4:0] XSEL_N    = 5'b00001;
    localparam logic [4:0] XSEL_E    = 5'b00010;
    localparam logic [4:0] XSEL_W    = 5'b00100;
    localparam logic [4:0] XSEL_S    = 5'b01000;
    localparam logic [4:0] XSEL_L    = 5'b10000;

    function automatic state_t port_state(input port_e p);
        case (p)
            P_L:     port_state = ST_L;
            P_N:     port_state = ST_N;
            P_E:     port_state = ST_E;
            P_W:     port_state = ST_W;
            P_S:     port_state = ST_S;
            default: port_state = ST_IDLE;
        endcase
    endfunction

    function automatic logic [4:0] state_xsel(input state_t s);
        case (s)
            ST_L:    state_xsel = XSEL_L;
            ST_N:    state_xsel = XSEL_N;
            ST_E:    state_xsel = XSEL_E;
            ST_W:    state_xsel = XSEL_W;
            ST_S:    state_xsel = XSEL_S;
            default: state_xsel = XSEL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/arbiter_rr5.sv
// Round-robin output-port arbiter with RTS/DCTS handshake toward the downstream router.
module arbiter_rr5
    import arbiter_rr5_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       Req_N,
    input  logic       Req_E,
    input  logic       Req_W,
    input  logic       Req_S,
    input  logic       Req_L,
    input  logic       DCTS,
    output logic       Grant_N,
    output logic       Grant_E,
    output logic       Grant_W,
    output logic       Grant_S,
    output logic       Grant_L,
    output logic [4:0] Xbar_sel,
    output logic       RTS
);

    state_t                 state, state_nxt;
    logic                   rts_ff, rts_nxt;
    logic [NUM_PORTS-1:0]   req;
    logic [2:0]             idx;
    logic                   found;
    logic                   gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rts_ff <= 1'b0;
        end else begin
            state  <= state_nxt;
            rts_ff <= rts_nxt;
        end
    end

    always_comb begin
        req        = '0;
        req[P_L]   = Req_L;
        req[P_N]   = Req_N;
        req[P_E]   = Req_E;
        req[P_W]   = Req_W;
        req[P_S]   = Req_S;
        state_nxt  = state;
        rts_nxt    = rts_ff;
        found      = 1'b0;
        idx        = P_L;

        if (rts_ff) begin
            if (DCTS)
                rts_nxt = 1'b0;
        end else begin
            // Search starts at the port after the current owner; IDLE and S both start at L.
            case (state)
                ST_L:    idx = P_N;
                ST_N:    idx = P_E;
                ST_E:    idx = P_W;
                ST_W:    idx = P_S;
                default: idx = P_L;
            endcase
            state_nxt = ST_IDLE;
            rts_nxt   = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && req[idx]) begin
                    found     = 1'b1;
                    state_nxt = port_state(port_e'(idx));
                    rts_nxt   = 1'b1;
                end
                idx = (idx == 3'(NUM_PORTS - 1)) ? 3'd0 : idx + 3'd1;
            end
        end

        gnt      = rts_ff & DCTS;
        Grant_L  = gnt && (state == ST_L);
        Grant_N  = gnt && (state == ST_N);
        Grant_E  = gnt && (state == ST_E);
        Grant_W  = gnt && (state == ST_W);
        Grant_S  = gnt && (state == ST_S);
        Xbar_sel = state_xsel(state);
    end

    assign RTS = rts_ff;

endmodule

// File: tb/tb_arbiter_rr5.sv
// Self-checking bench for arbiter_rr5: directed scenarios plus randomized run against an owner/priority-table model.
module tb_arbiter_rr5;

    logic       clk, rst;
    logic       Req_N, Req_E, Req_W, Req_S, Req_L, DCTS;
    logic       Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
    logic [4:0] Xbar_sel;
    logic       RTS;

    arbiter_rr5 dut (
        .clk(clk), .rst(rst),
        .Req_N(Req_N), .Req_E(Req_E), .Req_W(Req_W), .Req_S(Req_S), .Req_L(Req_L),
        .DCTS(DCTS),
        .Grant_N(Grant_N), .Grant_E(Grant_E), .Grant_W(Grant_W), .Grant_S(Grant_S),
        .Grant_L(Grant_L),
        .Xbar_sel(Xbar_sel), .RTS(RTS)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Model: owner 0=IDLE,1=L,2=N,3=E,4=W,5=S; priority lists straight from the rotation table.
    int prio [6][5] = '{'{1,2,3,4,5}, '{2,3,4,5,1}, '{3,4,5,1,2},
                        '{4,5,1,2,3}, '{5,1,2,3,4}, '{1,2,3,4,5}};
    logic [4:0] xsel_tab [6] = '{5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
    int   m_owner;
    bit   m_rts;

    int   tests, fails, cyc;
    logic [4:0] obs_g, obs_x, exp_g;
    logic       obs_r;
    int   gnt_owner[$];
    int   gnt_cyc[$];

    function automatic logic [4:0] model_grant(input bit d);
        model_grant = (m_rts && d && m_owner != 0) ? (5'b00001 << (5 - m_owner)) : 5'b00000;
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic sample();
        obs_g = {Grant_L, Grant_N, Grant_E, Grant_W, Grant_S};
        obs_x = Xbar_sel;
        obs_r = RTS;
    endtask

    task automatic check_model();
        sample();
        exp_g = model_grant(DCTS);
        chk("grant", obs_g, exp_g);
        chk("xbar", obs_x, xsel_tab[m_owner]);
        chk("rts", {4'b0, obs_r}, {4'b0, m_rts});
        chk("onehot0", {4'b0, $onehot0(obs_g)}, 5'd1);
        if (obs_g != 0) begin
            chk("gnt_rts_dcts", {3'b0, obs_r, DCTS}, 5'b00011);
            chk("xbar_vs_gnt", obs_x, {obs_g[4], obs_g[0], obs_g[1], obs_g[2], obs_g[3]});
        end
    endtask

    task automatic model_update(input logic [4:0] r, input bit d, input bit rs);
        bit req_m [6];
        bit hit;
        req_m[0] = 1'b0;
        for (int i = 1; i <= 5; i++) req_m[i] = r[5 - i];
        if (rs) begin
            m_owner = 0; m_rts = 0;
        end else if (m_rts) begin
            if (d) m_rts = 0;
        end else begin
            hit = 0;
            foreach (prio[m_owner][k]) begin
                if (!hit && req_m[prio[m_owner][k]]) begin
                    hit = 1;
                    m_owner = prio[m_owner][k];
                end
            end
            if (!hit) m_owner = 0;
            m_rts = hit;
        end
    endtask

    // r is {L,N,E,W,S}
    task automatic step(input logic [4:0] r, input bit d, input bit rs);
        @(negedge clk);
        {Req_L, Req_N, Req_E, Req_W, Req_S} = r;
        DCTS = d;
        rst  = rs;
        #1;
        check_model();
        if (obs_g != 0) begin
            for (int i = 1; i <= 5; i++)
                if (obs_g[5 - i]) gnt_owner.push_back(i);
            gnt_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        model_update(r, d, rs);
    endtask

    initial begin
        int exp_seq [6] = '{1, 2, 3, 4, 5, 1};
        logic [4:0] rr;
        tests = 0; fails = 0; cyc = 0;
        m_owner = 0; m_rts = 0;
        rst = 1'b0; DCTS = 1'b0;
        {Req_L, Req_N, Req_E, Req_W, Req_S} = 5'b11111;

        // Reset with every request high.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sample();
        chk("rst_grant", obs_g, 5'b00000);
        chk("rst_xbar", obs_x, 5'b00000);
        chk("rst_rts", {4'b0, obs_r}, 5'd0);

        // North alone: RTS next cycle, grant with DCTS, RTS drops after.
        step(5'b01000, 1'b0, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        chk("n_rts", {4'b0, obs_r}, 5'd1);
        chk("n_xbar", obs_x, 5'b00001);
        chk("n_grant", obs_g, 5'b01000);
        step(5'b00000, 1'b0, 1'b0);
        chk("n_rts_drop", {4'b0, obs_r}, 5'd0);
        step(5'b00000, 1'b0, 1'b0);
        chk("idle_xbar", obs_x, 5'b00000);

        // All requests, DCTS held: rotation L,N,E,W,S,L at one grant per 2 cycles.
        gnt_owner.delete(); gnt_cyc.delete();
        for (int i = 0; i < 12; i++) step(5'b11111, 1'b1, 1'b0);
        chk("rot_count", 5'(gnt_owner.size()), 5'd6);
        for (int i = 0; i < 6 && i < gnt_owner.size(); i++)
            chk("rot_owner", 5'(gnt_owner[i]), 5'(exp_seq[i]));
        for (int i = 1; i < gnt_cyc.size(); i++)
            chk("rot_spacing", 5'(gnt_cyc[i] - gnt_cyc[i-1]), 5'd2);

        // Drain, then hold East waiting on DCTS for 5 cycles.
        step(5'b00000, 1'b1, 1'b0);
        step(5'b00000, 1'b1, 1'b0);
        step(5'b00100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(5'b00000, 1'b0, 1'b0);
            chk("e_wait_rts", {4'b0, obs_r}, 5'd1);
            chk("e_wait_xbar", obs_x, 5'b00010);
            chk("e_wait_gnt", obs_g, 5'b00000);
        end
        step(5'b00000, 1'b1, 1'b0);
        chk("e_grant", obs_g, 5'b00100);
        step(5'b00000, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        chk("after_idle_xbar", obs_x, 5'b00000);
        chk("after_idle_rts", {4'b0, obs_r}, 5'd0);

        // Randomized run with occasional resets mid-handshake.
        for (int i = 0; i < 400; i++) begin
            rr = 5'($urandom);
            step(rr, 1'($urandom), ($urandom_range(0, 39) == 0));
        end
        step(5'b00000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
